adder_serial_n_bit: RTL and testbench

Parametrised multi-cycle ripple adder/subtractor, the successor to the fixed-width combinational adders. It latches two WIDTH-bit operands on a start handshake and processes DIGIT bits per clock, carrying between digits through a carry register. It reports sum, carry-out and signed overflow with a one-cycle done pulse. It is used where a full-width combinational carry chain is too long for the clock period, or where area must be traded for latency.

---
 rtl/adder_serial_n_bit.sv | 121 ++++++++++++
 tb/tb_adder_serial_n_bit.sv | 203 ++++++++++++++++++++
 2 files changed

// File: rtl/adder_serial_n_bit.sv
// Multi-cycle ripple adder/subtractor.
// Latches two WIDTH-bit operands on an accepted start and processes DIGIT
// bits per clock. The carry between digits is held in a carry register.
// It reports sum, carry-out and signed overflow with a one-cycle done pulse.
module adder_serial_n_bit #(
  parameter int WIDTH = 8,
  parameter int DIGIT = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             sub,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic             Cin,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] S,
  output logic             Cout,
  output logic             V
);

  localparam int N  = WIDTH / DIGIT;
  localparam int CW = (N > 1) ? $clog2(N) : 1;
  localparam logic [CW-1:0]    LAST  = CW'(N - 1);
  localparam logic [WIDTH-1:0] DMASK = WIDTH'({DIGIT{1'b1}});

  generate
    if (WIDTH < 1 || DIGIT < 1 || (WIDTH % DIGIT) != 0) begin : g_bad_params
      $error("adder_serial_n_bit: WIDTH must be a positive multiple of DIGIT");
    end
  endgenerate

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t           r_state;
  state_t           w_next;
  logic [WIDTH-1:0] r_a;
  logic [WIDTH-1:0] r_b;
  logic [WIDTH-1:0] r_s;
  logic             r_carry;
  logic             r_cout;
  logic             r_v;
  logic [CW-1:0]    r_k;

  logic             w_accept;
  logic             w_last;
  int unsigned      w_base;
  logic [DIGIT-1:0] w_a_dig;
  logic [DIGIT-1:0] w_b_dig;
  logic [DIGIT:0]   w_sum;
  logic             w_v;
  logic [WIDTH-1:0] w_s_next;

  assign w_accept = start && ((r_state == IDLE) || (r_state == DONE));
  assign w_last   = (r_k == LAST);

  // Digit slice of the latched operands, its sum, and the merged partial result.
  // Shifts and masks stand in for variable part-selects.
  always_comb begin
    w_base   = 32'(r_k) * DIGIT;
    w_a_dig  = DIGIT'(r_a >> w_base);
    w_b_dig  = DIGIT'(r_b >> w_base);
    w_sum    = {1'b0, w_a_dig} + {1'b0, w_b_dig} + {{DIGIT{1'b0}}, r_carry};
    // The carry into the MSB is a^b^s at that bit. The overflow flag is that carry XOR carry-out.
    w_v      = w_a_dig[DIGIT-1] ^ w_b_dig[DIGIT-1] ^ w_sum[DIGIT-1] ^ w_sum[DIGIT];
    w_s_next = (r_s & ~(DMASK << w_base)) | (WIDTH'(w_sum[DIGIT-1:0]) << w_base);
  end

  // Next-state logic: IDLE/DONE accept start, RUN lasts N cycles, DONE lasts one cycle.
  always_comb begin
    w_next = r_state;
    case (r_state)
      IDLE:    if (start) w_next = RUN;
      RUN:     if (w_last) w_next = DONE;
      DONE:    w_next = start ? RUN : IDLE;
      default: w_next = IDLE;
    endcase
  end

  // State register with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) r_state <= IDLE;
    else     r_state <= w_next;
  end

  // Datapath: latch operands on accept, then ripple one digit per RUN cycle.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_a     <= '0;
      r_b     <= '0;
      r_s     <= '0;
      r_carry <= 1'b0;
      r_cout  <= 1'b0;
      r_v     <= 1'b0;
      r_k     <= '0;
    end else if (w_accept) begin
      r_a     <= A;
      r_b     <= B ^ {WIDTH{sub}};
      r_carry <= Cin ^ sub;
      r_k     <= '0;
      r_cout  <= 1'b0;
      r_v     <= 1'b0;
    end else if (r_state == RUN) begin
      r_s     <= w_s_next;
      r_carry <= w_sum[DIGIT];
      r_k     <= w_last ? '0 : r_k + 1'b1;
      if (w_last) begin
        r_cout <= w_sum[DIGIT];
        r_v    <= w_v;
      end
    end
  end

  assign busy = (r_state == RUN);
  assign done = (r_state == DONE);
  assign S    = r_s;
  assign Cout = r_cout;
  assign V    = r_v;

endmodule

// File: tb/tb_adder_serial_n_bit.sv
// Testbench for adder_serial_n_bit.
// Three instances: 8/2, 8/8 (single cycle), 12/3. Directed tests plus randomized
// operations, checked against an arithmetic reference model.
module tb_adder_serial_n_bit;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  logic        st0, sb0, ci0, bz0, dn0, co0, v0;
  logic [7:0]  a0, b0, s0;
  logic        st1, sb1, ci1, bz1, dn1, co1, v1;
  logic [7:0]  a1, b1, s1;
  logic        st2, sb2, ci2, bz2, dn2, co2, v2;
  logic [11:0] a2, b2, s2;

  int n_checks = 0;
  int n_pass   = 0;

  adder_serial_n_bit #(.WIDTH(8), .DIGIT(2)) u_d0 (
    .clk(clk), .rst(rst), .start(st0), .sub(sb0), .A(a0), .B(b0), .Cin(ci0),
    .busy(bz0), .done(dn0), .S(s0), .Cout(co0), .V(v0));
  adder_serial_n_bit #(.WIDTH(8), .DIGIT(8)) u_d1 (
    .clk(clk), .rst(rst), .start(st1), .sub(sb1), .A(a1), .B(b1), .Cin(ci1),
    .busy(bz1), .done(dn1), .S(s1), .Cout(co1), .V(v1));
  adder_serial_n_bit #(.WIDTH(12), .DIGIT(3)) u_d2 (
    .clk(clk), .rst(rst), .start(st2), .sub(sb2), .A(a2), .B(b2), .Cin(ci2),
    .busy(bz2), .done(dn2), .S(s2), .Cout(co2), .V(v2));

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    assert (got === exp) n_pass++;
    else $error("FAIL %s: got %0h, expected %0h", tag, got, exp);
  endtask

  task automatic drive(input int u, input logic [11:0] a, input logic [11:0] b,
                       input logic ci, input logic sb, input logic st);
    case (u)
      0:       begin a0 = a[7:0]; b0 = b[7:0]; ci0 = ci; sb0 = sb; st0 = st; end
      1:       begin a1 = a[7:0]; b1 = b[7:0]; ci1 = ci; sb1 = sb; st1 = st; end
      default: begin a2 = a;      b2 = b;      ci2 = ci; sb2 = sb; st2 = st; end
    endcase
  endtask

  task automatic rd(input int u, output logic bz, output logic dn, output logic co,
                    output logic v, output logic [11:0] s);
    case (u)
      0:       begin bz = bz0; dn = dn0; co = co0; v = v0; s = {4'h0, s0}; end
      1:       begin bz = bz1; dn = dn1; co = co1; v = v1; s = {4'h0, s1}; end
      default: begin bz = bz2; dn = dn2; co = co2; v = v2; s = s2; end
    endcase
  endtask

  // Reference: unsigned sum for S/Cout, true signed result range test for V.
  function automatic void model(input int w, input logic [11:0] a, input logic [11:0] b,
                                input logic ci, input logic sb, output logic [11:0] s,
                                output logic co, output logic v);
    longint mask, half, ua, ub, c, u, sa, sbv, r;
    mask = (64'sd1 <<< w) - 64'sd1;
    half = 64'sd1 <<< (w - 1);
    ua   = {52'd0, a} & mask;
    ub   = {52'd0, b} & mask;
    c    = ci ? 64'sd1 : 64'sd0;
    u    = sb ? (ua + (mask - ub) + (64'sd1 - c)) : (ua + ub + c);
    s    = 12'(u & mask);
    co   = ((u >>> w) & 64'sd1) != 64'sd0;
    sa   = (ua >= half) ? ua - 2 * half : ua;
    sbv  = (ub >= half) ? ub - 2 * half : ub;
    r    = sb ? (sa - sbv - c) : (sa + sbv + c);
    v    = (r < -half) || (r > half - 64'sd1);
  endfunction

  // One complete operation with junk on the inputs during RUN. Checks latency and the result.
  task automatic run_op(input int u, input int w, input int n, input logic [11:0] a,
                        input logic [11:0] b, input logic ci, input logic sb, input string tag);
    logic [11:0] es, s;
    logic        eco, ev, bz, dn, co, v;
    int          lat;
    model(w, a, b, ci, sb, es, eco, ev);
    drive(u, a, b, ci, sb, 1'b1);
    lat = 0;
    for (int c = 1; c <= n + 3 && lat == 0; c++) begin
      @(negedge clk);
      drive(u, 12'($urandom), 12'($urandom), 1'($urandom), 1'($urandom), 1'b0);
      rd(u, bz, dn, co, v, s);
      if (dn) lat = c;
    end
    chk({tag, "_lat"},  lat, n + 1);
    chk({tag, "_S"},    32'(s), 32'(es));
    chk({tag, "_Cout"}, 32'(co), 32'(eco));
    chk({tag, "_V"},    32'(v), 32'(ev));
  endtask

  initial begin
    logic [11:0] s;
    logic        bz, dn, co, v;
    int          lat, seen;

    rst = 1'b1;
    for (int u = 0; u < 3; u++) drive(u, '0, '0, 1'b0, 1'b0, 1'b0);
    repeat (2) @(negedge clk);
    for (int u = 0; u < 3; u++) begin
      rd(u, bz, dn, co, v, s);
      chk("rst_busy", 32'(bz), 0);
      chk("rst_done", 32'(dn), 0);
      chk("rst_S",    32'(s),  0);
      chk("rst_Cout", 32'(co), 0);
      chk("rst_V",    32'(v),  0);
    end
    rst = 1'b0;

    // Test 1: FF+01. busy in cycles 1-4, done in cycle 5 only.
    drive(0, 12'hFF, 12'h01, 1'b0, 1'b0, 1'b1);
    for (int c = 1; c <= 6; c++) begin
      @(negedge clk);
      drive(0, 12'hFF, 12'h01, 1'b0, 1'b0, 1'b0);
      rd(0, bz, dn, co, v, s);
      chk("t1_busy", 32'(bz), 32'(c <= 4));
      chk("t1_done", 32'(dn), 32'(c == 5));
      if (c == 5) begin
        chk("t1_S",    32'(s),  32'h00);
        chk("t1_Cout", 32'(co), 1);
        chk("t1_V",    32'(v),  0);
      end
    end

    // Tests 2 and 3: overflow and subtraction corners.
    run_op(0, 8, 4, 12'h7F, 12'h01, 1'b0, 1'b0, "t2a");
    @(negedge clk); rd(0, bz, dn, co, v, s);
    chk("t2a_hold_S", 32'(s), 32'h80);
    chk("t2a_hold_V", 32'(v), 1);
    run_op(0, 8, 4, 12'h80, 12'h80, 1'b0, 1'b0, "t2b");
    run_op(0, 8, 4, 12'h05, 12'h07, 1'b0, 1'b1, "t3a");
    @(negedge clk); rd(0, bz, dn, co, v, s);
    chk("t3a_hold_S", 32'(s), 32'hFE);
    chk("t3a_hold_Cout", 32'(co), 0);
    run_op(0, 8, 4, 12'h07, 12'h05, 1'b1, 1'b1, "t3b");

    // Test 4: start while busy is ignored. Back-to-back start is accepted in DONE.
    drive(0, 12'h10, 12'h20, 1'b0, 1'b0, 1'b1);
    @(negedge clk); drive(0, 12'h10, 12'h20, 1'b0, 1'b0, 1'b0);
    @(negedge clk); drive(0, 12'hFF, 12'hFF, 1'b0, 1'b0, 1'b1);
    @(negedge clk); drive(0, 12'hFF, 12'hFF, 1'b1, 1'b1, 1'b0);
    lat = 0;
    for (int c = 4; c <= 9 && lat == 0; c++) begin
      @(negedge clk); rd(0, bz, dn, co, v, s);
      if (dn) lat = c;
    end
    chk("t4_lat", lat, 5);
    chk("t4_S",   32'(s), 32'h30);
    drive(0, 12'h01, 12'h02, 1'b0, 1'b0, 1'b1);
    @(negedge clk); rd(0, bz, dn, co, v, s);
    chk("t4_b2b_busy", 32'(bz), 1);
    drive(0, 12'hAB, 12'hCD, 1'b1, 1'b1, 1'b0);
    lat = 0;
    for (int c = 2; c <= 8 && lat == 0; c++) begin
      @(negedge clk); rd(0, bz, dn, co, v, s);
      if (dn) lat = c;
    end
    chk("t4_b2b_lat", lat, 5);
    chk("t4_b2b_S",   32'(s), 32'h03);
    @(negedge clk); rd(0, bz, dn, co, v, s);
    chk("t4_idle_done", 32'(dn), 0);
    chk("t4_idle_busy", 32'(bz), 0);
    chk("t4_idle_S",    32'(s),  32'h03);

    // Test 5: reset during RUN discards the operation.
    drive(0, 12'h33, 12'h44, 1'b1, 1'b0, 1'b1);
    @(negedge clk); drive(0, 12'h33, 12'h44, 1'b1, 1'b0, 1'b0);
    @(negedge clk); rst = 1'b1;
    @(negedge clk); rst = 1'b0;
    rd(0, bz, dn, co, v, s);
    chk("t5_busy", 32'(bz), 0);
    chk("t5_done", 32'(dn), 0);
    chk("t5_S",    32'(s),  0);
    chk("t5_Cout", 32'(co), 0);
    chk("t5_V",    32'(v),  0);
    seen = 0;
    repeat (6) begin
      @(negedge clk); rd(0, bz, dn, co, v, s);
      if (dn) seen = 1;
    end
    chk("t5_no_done", seen, 0);
    run_op(0, 8, 4, 12'h0A, 12'h05, 1'b0, 1'b0, "t5b");
    @(negedge clk); rd(0, bz, dn, co, v, s);
    chk("t5b_hold_S", 32'(s), 32'h0F);

    // Test 6: single-cycle configuration.
    run_op(1, 8, 1, 12'hAA, 12'h55, 1'b1, 1'b0, "t6");
    @(negedge clk); rd(1, bz, dn, co, v, s);
    chk("t6_hold_S",    32'(s),  32'h00);
    chk("t6_hold_Cout", 32'(co), 1);

    // Randomized operations on all three configurations.
    repeat (40) run_op(0, 8, 4, 12'($urandom), 12'($urandom), 1'($urandom), 1'($urandom), "rnd0");
    repeat (40) run_op(1, 8, 1, 12'($urandom), 12'($urandom), 1'($urandom), 1'($urandom), "rnd1");
    repeat (1000) run_op(2, 12, 4, 12'($urandom), 12'($urandom), 1'($urandom), 1'($urandom), "rnd2");

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
